// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven IDLE/RUN/PAUSE/DONE controller for an
// up-counter with prescaler, terminal-count limit and one-shot/auto-reload.
// Ports: clk, rst_n (async low); cmd_valid/cmd_ready/cmd_op/cmd_data handshake;
// presc, mode_reload (sampled on START); count, state, busy, done, err.
// Optional: `define CNT_DOWN_EN adds count_dir (sampled on START, 1 = down).
module counter_sequencer #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [PRESC_W-1:0] presc,
  input  logic               mode_reload,
`ifdef CNT_DOWN_EN
  input  logic               count_dir,
`endif
  output logic [WIDTH-1:0]   count,
  output logic [1:0]         state,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t               st;
  logic [WIDTH-1:0]     limit;
  logic [PRESC_W-1:0]   pcnt;
  logic [PRESC_W-1:0]   presc_r;
  logic                 reload_r;
  logic                 accept;
  logic                 tick;
  logic                 tc;
  logic [WIDTH-1:0]     cnt_step;
  logic [WIDTH-1:0]     cnt_reload;

  assign accept = cmd_valid & cmd_ready;
  assign tick   = (st == RUN) && (pcnt == presc_r);
  assign state  = st;
  assign busy   = (st == RUN);

`ifdef CNT_DOWN_EN
  logic dir_r;

  // Down mode terminates at zero and reloads from the limit.
  assign tc         = dir_r ? (count == '0) : (count == limit);
  assign cnt_step   = dir_r ? count - WIDTH'(1) : count + WIDTH'(1);
  assign cnt_reload = dir_r ? limit : '0;
`else
  assign tc         = (count == limit);
  assign cnt_step   = count + WIDTH'(1);
  assign cnt_reload = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      count     <= '0;
      limit     <= '1;
      pcnt      <= '0;
      presc_r   <= '0;
      reload_r  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef CNT_DOWN_EN
      dir_r     <= 1'b0;
`endif
    end else begin
      // One dead cycle after every accepted command.
      cmd_ready <= ~accept;
      done      <= 1'b0;
      if (accept) begin
        // A command on a tick edge swallows that tick.
        unique case (cmd_op)
          OP_START: begin
            presc_r  <= presc;
            reload_r <= mode_reload;
`ifdef CNT_DOWN_EN
            dir_r    <= count_dir;
`endif
            if (st != PAUSE)
              pcnt <= '0;
            unique case (st)
              IDLE: begin
                st <= RUN;
`ifdef CNT_DOWN_EN
                if (count_dir)
                  count <= limit;
`endif
              end
              DONE: begin
                st    <= RUN;
                count <= '0;
`ifdef CNT_DOWN_EN
                if (count_dir)
                  count <= limit;
`endif
              end
              PAUSE: st <= RUN;
              RUN: ;
            endcase
          end
          OP_STOP: begin
            if (st == RUN)
              st <= PAUSE;
          end
          OP_LOAD: begin
            if (st == RUN)
              err <= 1'b1;
            else
              limit <= cmd_data;
          end
          OP_CLEAR: begin
            st    <= IDLE;
            count <= '0;
            pcnt  <= '0;
            err   <= 1'b0;
          end
        endcase
      end else if (tick) begin
        pcnt <= '0;
        if (tc) begin
          done <= 1'b1;
          if (reload_r)
            count <= cnt_reload;
          else
            st <= DONE;
        end else begin
          count <= cnt_step;
        end
      end else if (st == RUN) begin
        pcnt <= pcnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller for an 8-bit up-counter datapath. It owns the count register and sequences it through idle/run/pause/done states. It provides a programmable prescaler, a terminal-count limit with one-shot or auto-reload, and a valid/ready command interface. It sits between the tile input pins (command decode) and the output mux that presents the count value.

Parameters:
WIDTH, 8, counter and limit width
PRESC_W, 4, prescaler reload width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 START, 01 STOP, 10 LOAD_LIMIT, 11 CLEAR
cmd_data  input  WIDTH  limit value for LOAD_LIMIT
presc  input  PRESC_W  prescaler value, sampled on START
mode_reload  input  1  sampled on START; 1 = auto-reload, 0 = one-shot
count  output  WIDTH  current count
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
busy  output  1  high when state is RUN
done  output  1  one-cycle pulse on terminal count
err  output  1  sticky; set by LOAD_LIMIT while in RUN

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, limit=all ones (255), prescaler counter=0, presc_r=0, reload_r=0, done=0, err=0, cmd_ready=1. busy=0.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready drops for exactly the one cycle after an accept, then returns to 1.
  - Back-to-back commands therefore take 2 cycles each.
  - cmd_op and cmd_data are ignored when not accepted.
- START:
  - IDLE→RUN: count unchanged.
  - PAUSE→RUN: count and prescaler phase kept.
  - DONE→RUN: count cleared to 0.
  - In RUN: no effect.
  - On every accepted START: latch presc and mode_reload, and clear the prescaler counter except on PAUSE→RUN.
- STOP: RUN→PAUSE. No effect in other states.
- LOAD_LIMIT:
  - In IDLE, PAUSE or DONE: limit←cmd_data.
  - In RUN: limit unchanged and err set.
- CLEAR: from any state go to IDLE with count=0, prescaler counter=0, err=0. limit is kept.
- Prescaler: active only in RUN.
  - The prescaler counter increments each cycle.
  - When it equals presc_r it wraps to 0 and asserts an internal tick that cycle.
  - Tick period is presc_r+1 cycles; presc=0 gives a tick every cycle.
- On tick, if count==limit (terminal count):
  - done pulses for one cycle.
  - reload_r=1: count←0 and stay in RUN.
  - reload_r=0: count holds at limit and state→DONE.
- On tick, if count!=limit: count←count+1, modulo 2^WIDTH.
- First tick after START: occurs presc_r+1 cycles after the accept edge.
- Boundary cases:
  - limit=0: the first tick gives terminal count immediately (done without counting).
  - limit=255 with reload: count wraps 255→0 with a done pulse.
  - A command accepted on the same edge as a tick takes priority over the tick. The tick is discarded, with no count change and no done.
- Reset asserted mid-run forces the reset values immediately, regardless of clk.

Optional Feature:
Macro CNT_DOWN_EN.
- Defined:
  - Extra input port count_dir (1 bit), sampled on START.
  - count_dir=1 means down-count. START from IDLE or DONE loads count←limit.
  - Each tick decrements; terminal count is count==0.
  - With reload, count←limit on terminal count.
  - PAUSE→RUN resume keeps count.
- Not defined: the port is absent and behaviour is up-count only, as above.

Test Plan:
- Reset then idle: after reset release, count=0, state=00, limit=255, cmd_ready=1, err=0, done never pulses over 20 cycles.
- LOAD_LIMIT 5, START with presc=0 and mode_reload=0:
  - count steps 0,1,2,3,4,5 on consecutive cycles.
  - On the tick where count=5, done pulses once, state→DONE, count holds 5.
- LOAD_LIMIT 3, START with presc=2 and mode_reload=1:
  - Count advances every 3 cycles: 0→1→2→3→0.
  - done pulses every 12 cycles; state stays RUN.
- Pause/resume: START with presc=0 and limit=255, STOP after count=10.
  - count holds 10 for 8 cycles with busy=0.
  - A second START resumes and reaches 11 on the next tick.
- Error/clear: LOAD_LIMIT 7 while in RUN.
  - err=1 and limit stays unchanged.
  - CLEAR gives state=IDLE, count=0, err=0, and limit is still the pre-error value.
- Async reset mid-run with count=0x42: count=0 and state=IDLE while rst_n is low, before any clk edge.
  - CNT_DOWN_EN build: START with count_dir=1 and limit=4 counts 4,3,2,1,0, then done and DONE.
